// File: rtl/twiddle_pkg.sv
// twiddle_pkg: float32 constants (FP_ONE, FP_ZERO, SIGN_BIT), quadrant type and qcos(), which builds one quarter-wave cosine table entry rounded to nearest even
package twiddle_pkg;
  localparam logic [31:0] FP_ONE = 32'h3F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] SIGN_BIT = 32'h8000_0000;
  typedef enum logic {Q_FIRST, Q_SECOND} quadrant_t;
  function automatic logic [31:0] qcos(input int log2n, input int m);
    logic [63:0] d;
    logic [31:0] f;
    d = $realtobits($cos(2.0 * 3.141592653589793 * m / (1 << log2n)));
    f = {1'b0, 8'(d[62:52] - 11'd896), d[51:29]} + 32'(d[28] & (|d[27:0] | d[29]));
    qcos = (m == 0) ? FP_ONE : (d[63] || m >= (1 << (log2n - 2))) ? FP_ZERO : f;
  endfunction
endpackage

// File: rtl/twiddle_quarter_rom.sv
// twiddle_quarter_rom: N/4+1 entry cosine ROM; ports clk, rst, en (read enable), addr_a/addr_b in, data_a/data_b registered out
module twiddle_quarter_rom
  import twiddle_pkg::*;
#(
  parameter int LOG2N = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [LOG2N-2:0] addr_a,
  input  logic [LOG2N-2:0] addr_b,
  output logic [31:0]      data_a,
  output logic [31:0]      data_b
);
  localparam int Q = 1 << (LOG2N - 2);
  logic [31:0] tab [0:Q];
  for (genvar i = 0; i <= Q; i++) begin : g_tab
    localparam logic [31:0] V = qcos(LOG2N, i);
    assign tab[i] = V;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data_a <= FP_ZERO;
      data_b <= FP_ZERO;
    end else if (en) begin
      data_a <= tab[addr_a];
      data_b <= tab[addr_b];
    end
  end
endmodule

// File: rtl/twiddle_seq_gen.sv
// twiddle_seq_gen: radix-2 FFT twiddle streamer; in start/stage/inverse/out_ready, out busy/out_valid/w_re/w_im/w_idx/out_last; TWIDDLE_INVERSE_EN enables conjugation
module twiddle_seq_gen
  import twiddle_pkg::*;
#(
  parameter int LOG2N = 5,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       stage,
  input  logic             inverse,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    w_re,
  output logic [DW-1:0]    w_im,
  output logic [LOG2N-2:0] w_idx,
  output logic             out_last
);
  localparam int KW = LOG2N - 1;
  localparam logic [KW-1:0] Q = KW'(1 << (LOG2N - 2));
  logic en, run, p1_valid, p1_last, p2_neg_re, neg_im;
  quadrant_t p1_quad;
  logic [KW-1:0] b, k, m, p1_k, addr_a, addr_b;
  logic [3:0] s_r;
  logic [31:0] rom_a, rom_b;
  assign en = !out_valid || out_ready;
  assign k = (b & KW'((1 << s_r) - 1)) << (4'(KW) - s_r);
  assign m = p1_k - Q;
  assign addr_a = (p1_quad == Q_FIRST) ? p1_k : Q - m;
  assign addr_b = (p1_quad == Q_FIRST) ? Q - p1_k : m;
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      run <= 1'b0;
      b <= '0;
      s_r <= '0;
      p1_valid <= 1'b0;
      p1_k <= '0;
      p1_quad <= Q_FIRST;
      p1_last <= 1'b0;
      out_valid <= 1'b0;
      w_idx <= '0;
      out_last <= 1'b0;
      p2_neg_re <= 1'b0;
    end else begin
      if (start && !busy) begin
        busy <= 1'b1;
        run <= 1'b1;
        b <= '0;
        s_r <= (stage >= 4'(LOG2N)) ? 4'(KW) : stage;
      end else if (out_valid && out_ready && out_last) begin
        busy <= 1'b0;
      end
      if (en) begin
        p1_valid <= run;
        if (run) begin
          p1_k <= k;
          p1_quad <= (k > Q) ? Q_SECOND : Q_FIRST;
          p1_last <= &b;
          b <= b + 1'b1;
          run <= !(&b);
        end
        out_valid <= p1_valid;
        w_idx <= p1_k;
        out_last <= p1_valid && p1_last;
        p2_neg_re <= p1_quad == Q_SECOND;
      end
    end
  end
`ifdef TWIDDLE_INVERSE_EN
  logic p1_inv, p2_inv;
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_inv <= 1'b0;
      p2_inv <= 1'b0;
    end else begin
      if (start && !busy) p1_inv <= inverse;
      if (en) p2_inv <= p1_inv;
    end
  end
  assign neg_im = !p2_inv;
`else
  logic unused_inverse;
  assign unused_inverse = inverse;
  assign neg_im = 1'b1;
`endif
  twiddle_quarter_rom #(.LOG2N(LOG2N)) u_rom (
    .clk,
    .rst,
    .en,
    .addr_a,
    .addr_b,
    .data_a(rom_a),
    .data_b(rom_b)
  );
  assign w_re = ~|(rom_a & ~SIGN_BIT) ? FP_ZERO : rom_a ^ (p2_neg_re ? SIGN_BIT : FP_ZERO);
  assign w_im = ~|(rom_b & ~SIGN_BIT) ? FP_ZERO : rom_b ^ (neg_im ? SIGN_BIT : FP_ZERO);
endmodule

// File: tb/tb_twiddle_seq_gen.sv
// tb_twiddle_seq_gen: scoreboard bench with a trigonometric reference model for twiddle_seq_gen
module tb_twiddle_seq_gen;
  localparam int LOG2N = 5;
  localparam int N = 1 << LOG2N;
  localparam int H = N / 2;
  localparam int KW = LOG2N - 1;
  localparam real PI = 3.141592653589793;
  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
    logic [KW-1:0] idx;
    logic last;
  } exp_t;
  logic clk = 1'b0;
  logic rst, start, inverse, out_ready, busy, out_valid, out_last;
  logic [3:0] stage;
  logic [31:0] w_re, w_im;
  logic [KW-1:0] w_idx;
  logic [31:0] seen_re [H];
  logic [31:0] seen_im [H];
  exp_t q[$];
  int checks = 0, passes = 0, pops = 0;
  always #5 clk = ~clk;
  twiddle_seq_gen #(.LOG2N(LOG2N), .DW(32)) dut (
    .clk(clk), .rst(rst), .start(start), .stage(stage), .inverse(inverse),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .w_re(w_re), .w_im(w_im), .w_idx(w_idx), .out_last(out_last)
  );
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h required %0h", nm, act, req);
  endtask
  function automatic logic [31:0] f32(input real x);
    real a, f;
    int e;
    longint mi;
    logic sgn;
    if (x < 1.0e-9 && x > -1.0e-9) return 32'h0;
    sgn = x < 0.0;
    a = sgn ? -x : x;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    f = (a - 1.0) * 8388608.0;
    mi = longint'($floor(f));
    if (f - $floor(f) > 0.5 || (f - $floor(f) == 0.5 && mi[0])) mi++;
    if (mi == 64'd8388608) begin mi = 0; e++; end
    return {sgn, 8'(e + 127), 23'(mi)};
  endfunction
  function automatic exp_t ref_elem(input int st, input int bb, input bit inv);
    int s, k;
    real th;
    bit conj;
    exp_t e;
    conj = 1'b0;
`ifdef TWIDDLE_INVERSE_EN
    conj = inv;
`endif
    s = (st > KW) ? KW : st;
    k = (bb % (1 << s)) * (1 << (KW - s));
    th = 2.0 * PI * k / N;
    e.re = f32($cos(th));
    e.im = f32(conj ? $sin(th) : -$sin(th));
    e.idx = KW'(k);
    e.last = (bb == H - 1);
    return e;
  endfunction
  task automatic start_seq(input int st, input bit inv);
    for (int i = 0; i < H; i++) q.push_back(ref_elem(st, i, inv));
    start = 1'b1;
    stage = 4'(st);
    inverse = inv;
    @(posedge clk); #1;
    start = 1'b0;
    chk("lat_t0_busy_valid", {busy, out_valid}, 2'b10);
    @(posedge clk); #1;
    chk("lat_t1_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    chk("lat_t2_valid", out_valid, 1'b1);
  endtask
  task automatic finish_seq(input bit rnd, input bit poke);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (q.size() == 0 && !busy && !out_valid) begin ok = 1'b1; break; end
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      start = poke && i == 3;
      stage = 4'd0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("seq_done", ok, 1'b1);
  endtask
  initial begin
    exp_t e;
    logic [KW+66:0] held;
    bit stalled;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (stalled && !rst) chk("hold_stable", {out_valid, out_last, w_idx, w_re, w_im}, held);
      stalled = !rst && out_valid && !out_ready;
      held = {out_valid, out_last, w_idx, w_re, w_im};
      if (!rst && out_valid && out_ready) begin
        pops++;
        seen_re[w_idx] = w_re;
        seen_im[w_idx] = w_im;
        if (q.size() == 0) begin
          checks++;
          $display("FAIL extra_element: got idx %0h required no element", w_idx);
        end else begin
          e = q.pop_front();
          chk("elem", {w_re, w_im, w_idx, out_last}, e);
        end
      end
    end
  end
  initial begin
    int base;
    rst = 1'b1;
    start = 1'b0;
    stage = 4'd0;
    inverse = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {busy, out_valid, out_last, w_idx, w_re, w_im}, 0);
    rst = 1'b0;
    start_seq(0, 0);
    finish_seq(0, 0);
    start_seq(4, 0);
    finish_seq(0, 0);
    chk("k1_re", seen_re[1], 32'h3F7B14BE);
    chk("k1_im", seen_im[1], 32'hBE47C5C2);
    chk("k8_re", seen_re[8], 32'h00000000);
    chk("k8_im", seen_im[8], 32'hBF800000);
    chk("k12_re", seen_re[12], 32'hBF3504F3);
    chk("k12_im", seen_im[12], 32'hBF3504F3);
    chk("k15_re", seen_re[15], 32'hBF7B14BE);
    chk("k15_im", seen_im[15], 32'hBE47C5C2);
    seen_re[8] = 32'hFFFFFFFF;
    start_seq(1, 0);
    finish_seq(0, 1);
    chk("stage1_k8_re", seen_re[8], 32'h00000000);
    repeat (5) @(posedge clk);
    #1;
    chk("start_while_busy_ignored", {busy, out_valid}, 2'b00);
    start_seq(4, 0);
    base = pops;
    for (int i = 0; i < 50 && pops < base + 5; i++) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    finish_seq(0, 0);
    start_seq(4, 1);
    finish_seq(0, 0);
`ifdef TWIDDLE_INVERSE_EN
    chk("inv_k4_im", seen_im[4], 32'h3F3504F3);
`else
    chk("inv_k4_im", seen_im[4], 32'hBF3504F3);
`endif
    chk("inv_k0_im", seen_im[0], 32'h00000000);
    for (int r = 0; r < 8; r++) begin
      start_seq(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      finish_seq(1, 0);
    end
    start_seq(4, 0);
    base = pops;
    for (int i = 0; i < 50 && pops < base + 7; i++) begin @(posedge clk); #1; end
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    chk("reset_mid_seq", {busy, out_valid, out_last, w_idx, w_re, w_im}, 0);
    rst = 1'b0;
    start_seq(4, 0);
    finish_seq(0, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/twiddle_seq_gen.md
# twiddle_seq_gen

Parametrised radix-2 FFT twiddle-factor sequencer producing IEEE-754 single-precision W_N^k = cos(2πk/N) − j·sin(2πk/N) for any N = 2^LOG2N. It stores only a quarter-wave cosine table and derives all N/2 factors by symmetry. On a start request for a given stage, it streams the per-butterfly twiddle sequence over a valid/ready handshake. It feeds the butterfly datapath in the FFT core and replaces fixed 16-entry lookup generators.

## Interface
- LOG2N, 5, log2 of FFT size N; legal range 3..12
- DW, 32, sample word width; fixed at 32 (IEEE-754 single)
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request a stage sequence; accepted only when busy=0
- stage  in  4  FFT stage s; values ≥ LOG2N are clamped to LOG2N−1
- inverse  in  1  conjugate output (IFFT); sampled on start acceptance
- busy  out  1  high from the cycle after start acceptance until the cycle after the final handshake
- out_valid  out  1  w_re/w_im/w_idx/out_last valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- w_re  out  32  real part, float32
- w_im  out  32  imaginary part, float32
- w_idx  out  LOG2N−1  twiddle exponent k
- out_last  out  1  marks the final (N/2-th) element of the sequence

## Operation
- Sequence: butterfly counter b runs 0..N/2−1. k = (b mod 2^s) << (LOG2N−1−s).
- Quarter table C[m] = cos(2πm/N), m = 0..N/4, N/4+1 entries.
- Fold for k ≤ N/4: re = C[k], im = −C[N/4−k].
- Fold for k > N/4 (m = k−N/4): re = −C[N/4−m], im = −C[m].
- Negation is a bit-31 flip only; no float arithmetic.
- Zero rule: a magnitude-zero result is always +0.0 (0x00000000). It is never 0x80000000.
- Inverse: im sign is flipped after the fold. The zero rule still applies.
- Flow: idle → run on start accept. Run → idle when the out_last element handshakes.
- start while busy=1 is ignored.
- start in the same cycle busy falls is ignored.
- rst mid-sequence: abandons the sequence. All state and outputs return to reset values on the next edge.

## Timing
- Reset values: busy=0, out_valid=0, w_re=0, w_im=0, w_idx=0, out_last=0.
- Pipeline has two register stages:
  - P1: register k, quadrant select and inverse.
  - P2: ROM read, fold, output register.
- Global enable = !out_valid | out_ready.
- start accepted at edge t → first out_valid high after edge t+2.
- Throughput is one element per cycle while out_ready=1.
- With out_ready=0 and out_valid=1, all outputs hold bit-stable. The counter and P1 do not advance.
- out_valid drops after the last handshake unless the next element is present. There is no bubble inside a sequence when out_ready stays high.

## Configuration
- TWIDDLE_INVERSE_EN defined: the inverse input is honoured as above.
- TWIDDLE_INVERSE_EN undefined: the inverse port stays present but is ignored, and output is always forward. The conjugate logic and its pipeline bit are removed.

## Structure
- Package twiddle_pkg holds:
  - Float constants: FP_ONE = 0x3F800000, FP_ZERO, SIGN_BIT.
  - The constant function that builds the quarter cosine table for a given LOG2N, using round-to-nearest-even float32 conversion.
  - The quadrant typedef.
- Sub-module twiddle_quarter_rom: parametrised by LOG2N, holds the N/4+1 entries. It has a registered read (P2) with a read-enable tied to the global enable.
- The sequencer, fold logic and handshake live in twiddle_seq_gen.

## Test plan
- LOG2N=5, stage=0, out_ready=1 → 16 elements, all w_re=0x3F800000, w_im=0x00000000. out_last on the 16th element; first valid 2 cycles after start.
- LOG2N=5, stage=4 → w_idx=0..15.
  - k=1: 0x3F7B14BE / 0xBE47C5C2
  - k=8: 0x00000000 / 0xBF800000
  - k=12: 0xBF3504F3 / 0xBF3504F3
  - k=15: 0xBF7B14BE / 0xBE47C5C2
- LOG2N=5, stage=1 → w_idx alternates 0, 8, 0, 8…; k=8 gives w_re=0x00000000 (never 0x80000000).
- TWIDDLE_INVERSE_EN defined, inverse=1, stage=4 → k=4 gives w_im=0x3F3504F3; k=0 gives w_im=0x00000000. With the macro undefined → k=4 gives w_im=0xBF3504F3.
- Stall: out_ready low for 3 cycles at element 5 → outputs held bit-stable; the element is not duplicated or skipped; still exactly 16 elements.
- start pulsed while busy → ignored. rst asserted at element 7 → next cycle has all outputs at reset values and busy=0. A fresh start then produces the full sequence from k=0.
